// File: rtl/fm_guard_pack_writer_if.sv
// fm_guard_pack_writer bus: layer control, byte/guard streams,
// FM and guard SRAM write ports, per-layer statistics.
interface fm_guard_pack_writer_if #(
  parameter int FM_WORD_BYTES = 8,
  parameter int GUARD_GROUPS  = 4,
  parameter int FM_ADDR_W     = 10,
  parameter int GUARD_ADDR_W  = 8
);
  logic                         ctrl_valid;
  logic                         ctrl_ready;
  logic                         ctrl_finish;
  logic [FM_ADDR_W-1:0]         fm_base_addr_i;
  logic [GUARD_ADDR_W-1:0]      guard_base_addr_i;
  logic                         upstream_finish_i;

  logic [7:0]                   data_i;
  logic                         data_i_valid;
  logic                         fm_buf_ready;
  logic [5:0]                   guard_i;
  logic                         guard_i_valid;
  logic                         guard_buf_ready;

  logic                         fm_wr_en;
  logic [FM_ADDR_W-1:0]         fm_wr_addr;
  logic [8*FM_WORD_BYTES-1:0]   fm_wr_data;
  logic [FM_WORD_BYTES-1:0]     fm_wr_mask;
  logic                         guard_wr_en;
  logic [GUARD_ADDR_W-1:0]      guard_wr_addr;
  logic [6*GUARD_GROUPS-1:0]    guard_wr_data;

  logic [15:0]                  stat_bytes_o;
  logic [15:0]                  stat_guards_o;

  modport master (
    output ctrl_valid, fm_base_addr_i, guard_base_addr_i,
    output upstream_finish_i,
    output data_i, data_i_valid, guard_i, guard_i_valid,
    input  ctrl_ready, ctrl_finish,
    input  fm_buf_ready, guard_buf_ready,
    input  fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
    input  guard_wr_en, guard_wr_addr, guard_wr_data,
    input  stat_bytes_o, stat_guards_o
  );

  modport slave (
    input  ctrl_valid, fm_base_addr_i, guard_base_addr_i,
    input  upstream_finish_i,
    input  data_i, data_i_valid, guard_i, guard_i_valid,
    output ctrl_ready, ctrl_finish,
    output fm_buf_ready, guard_buf_ready,
    output fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
    output guard_wr_en, guard_wr_addr, guard_wr_data,
    output stat_bytes_o, stat_guards_o
  );
endinterface

// File: rtl/fm_guard_pack_writer.sv
// Packs FM bytes / guard groups into SRAM words with end-of-layer flush.
// Optional FM_GUARD_STAT_EN adds saturating per-layer accept counters.
module fm_guard_pack_writer #(
  parameter int FM_WORD_BYTES = 8,
  parameter int GUARD_GROUPS  = 4,
  parameter int FM_ADDR_W     = 10,
  parameter int GUARD_ADDR_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  fm_guard_pack_writer_if.slave bus
);

  localparam int FLW = $clog2(FM_WORD_BYTES);
  localparam int GLW = $clog2(GUARD_GROUPS);
  localparam int FDW = 8 * FM_WORD_BYTES;
  localparam int GDW = 6 * GUARD_GROUPS;

  localparam logic [FLW-1:0] FM_LAST = FLW'(FM_WORD_BYTES - 1);
  localparam logic [GLW-1:0] G_LAST  = GLW'(GUARD_GROUPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic in_idle;
  logic in_run;
  logic in_flush;
  logic start;
  logic fm_acc;
  logic g_acc;

  assign in_idle  = (state == S_IDLE);
  assign in_run   = (state == S_RUN);
  assign in_flush = (state == S_FLUSH);
  assign start    = in_idle && bus.ctrl_valid;
  assign fm_acc   = in_run && bus.data_i_valid;
  assign g_acc    = in_run && bus.guard_i_valid;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (bus.upstream_finish_i) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign bus.ctrl_ready      = in_idle;
  assign bus.ctrl_finish     = (state == S_DONE);
  assign bus.fm_buf_ready    = in_run;
  assign bus.guard_buf_ready = in_run;

  // ---------------- FM lane ----------------
  logic [FLW-1:0]       fm_lane;
  logic [FDW-1:0]       fm_pack;
  logic [FDW-1:0]       fm_word;
  logic [FM_ADDR_W-1:0] fm_addr;
  logic [FM_WORD_BYTES-1:0] fm_part_mask;
  logic fm_full;
  logic fm_flush;

  logic                     fm_wr_en_q;
  logic [FM_ADDR_W-1:0]     fm_wr_addr_q;
  logic [FDW-1:0]           fm_wr_data_q;
  logic [FM_WORD_BYTES-1:0] fm_wr_mask_q;

  always_comb begin
    fm_word = fm_pack;
    fm_word[8*fm_lane +: 8] = bus.data_i;
  end

  // Flush mask covers lanes below the fill pointer.
  always_comb begin
    fm_part_mask = '0;
    for (int i = 0; i < FM_WORD_BYTES; i++)
      fm_part_mask[i] = (i < int'(fm_lane));
  end

  assign fm_full  = fm_acc && (fm_lane == FM_LAST);
  assign fm_flush = in_flush && (fm_lane != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_lane      <= '0;
      fm_pack      <= '0;
      fm_addr      <= '0;
      fm_wr_en_q   <= 1'b0;
      fm_wr_addr_q <= '0;
      fm_wr_data_q <= '0;
      fm_wr_mask_q <= '0;
    end else begin
      fm_wr_en_q <= 1'b0;
      if (start) begin
        fm_lane <= '0;
        fm_pack <= '0;
        fm_addr <= bus.fm_base_addr_i;
      end else if (fm_full) begin
        fm_wr_en_q   <= 1'b1;
        fm_wr_addr_q <= fm_addr;
        fm_wr_data_q <= fm_word;
        fm_wr_mask_q <= '1;
        fm_addr      <= fm_addr + FM_ADDR_W'(1);
        fm_lane      <= '0;
        fm_pack      <= '0;
      end else if (fm_acc) begin
        fm_pack <= fm_word;
        fm_lane <= fm_lane + FLW'(1);
      end else if (fm_flush) begin
        fm_wr_en_q   <= 1'b1;
        fm_wr_addr_q <= fm_addr;
        fm_wr_data_q <= fm_pack;
        fm_wr_mask_q <= fm_part_mask;
        fm_addr      <= fm_addr + FM_ADDR_W'(1);
        fm_lane      <= '0;
        fm_pack      <= '0;
      end
    end
  end

  assign bus.fm_wr_en   = fm_wr_en_q;
  assign bus.fm_wr_addr = fm_wr_addr_q;
  assign bus.fm_wr_data = fm_wr_data_q;
  assign bus.fm_wr_mask = fm_wr_mask_q;

  // ---------------- guard lane ----------------
  logic [GLW-1:0]          g_lane;
  logic [GDW-1:0]          g_pack;
  logic [GDW-1:0]          g_word;
  logic [GUARD_ADDR_W-1:0] g_addr;
  logic g_full;
  logic g_flush;

  logic                    g_wr_en_q;
  logic [GUARD_ADDR_W-1:0] g_wr_addr_q;
  logic [GDW-1:0]          g_wr_data_q;

  always_comb begin
    g_word = g_pack;
    g_word[6*g_lane +: 6] = bus.guard_i;
  end

  assign g_full  = g_acc && (g_lane == G_LAST);
  assign g_flush = in_flush && (g_lane != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_lane      <= '0;
      g_pack      <= '0;
      g_addr      <= '0;
      g_wr_en_q   <= 1'b0;
      g_wr_addr_q <= '0;
      g_wr_data_q <= '0;
    end else begin
      g_wr_en_q <= 1'b0;
      if (start) begin
        g_lane <= '0;
        g_pack <= '0;
        g_addr <= bus.guard_base_addr_i;
      end else if (g_full) begin
        g_wr_en_q   <= 1'b1;
        g_wr_addr_q <= g_addr;
        g_wr_data_q <= g_word;
        g_addr      <= g_addr + GUARD_ADDR_W'(1);
        g_lane      <= '0;
        g_pack      <= '0;
      end else if (g_acc) begin
        g_pack <= g_word;
        g_lane <= g_lane + GLW'(1);
      end else if (g_flush) begin
        g_wr_en_q   <= 1'b1;
        g_wr_addr_q <= g_addr;
        g_wr_data_q <= g_pack;
        g_addr      <= g_addr + GUARD_ADDR_W'(1);
        g_lane      <= '0;
        g_pack      <= '0;
      end
    end
  end

  assign bus.guard_wr_en   = g_wr_en_q;
  assign bus.guard_wr_addr = g_wr_addr_q;
  assign bus.guard_wr_data = g_wr_data_q;

  // ---------------- statistics ----------------
`ifdef FM_GUARD_STAT_EN
  logic [15:0] stat_b;
  logic [15:0] stat_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_b <= '0;
      stat_g <= '0;
    end else if (start) begin
      stat_b <= '0;
      stat_g <= '0;
    end else begin
      if (fm_acc && (stat_b != 16'hFFFF)) stat_b <= stat_b + 16'd1;
      if (g_acc && (stat_g != 16'hFFFF))  stat_g <= stat_g + 16'd1;
    end
  end

  assign bus.stat_bytes_o  = stat_b;
  assign bus.stat_guards_o = stat_g;
`else
  assign bus.stat_bytes_o  = 16'd0;
  assign bus.stat_guards_o = 16'd0;
`endif

endmodule

// File: tb/tb_fm_guard_pack_writer.sv
// Randomized + directed bench for fm_guard_pack_writer against a
// word-list reference model of the packing/flush rules.
module tb_fm_guard_pack_writer;

  localparam int W   = 8;
  localparam int G   = 4;
  localparam int FAW = 10;
  localparam int GAW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fm_guard_pack_writer_if #(
    .FM_WORD_BYTES(W), .GUARD_GROUPS(G),
    .FM_ADDR_W(FAW), .GUARD_ADDR_W(GAW)
  ) bus ();

  fm_guard_pack_writer #(
    .FM_WORD_BYTES(W), .GUARD_GROUPS(G),
    .FM_ADDR_W(FAW), .GUARD_ADDR_W(GAW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
    logic [7:0]  mask;
    logic        fin;
  } wr_t;

  wr_t fm_obs[$];
  wr_t g_obs[$];
  int  fin_cnt = 0;

  logic [7:0] bq[$];
  logic [5:0] gq[$];

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (bus.fm_wr_en)
      fm_obs.push_back('{64'(bus.fm_wr_data), 16'(bus.fm_wr_addr),
                         8'(bus.fm_wr_mask), bus.ctrl_finish});
    if (bus.guard_wr_en)
      g_obs.push_back('{64'(bus.guard_wr_data), 16'(bus.guard_wr_addr),
                        8'h00, bus.ctrl_finish});
    if (bus.ctrl_finish) fin_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t fm_at(input int i);
    wr_t r = '{64'hDEAD, 16'hFFFF, 8'h00, 1'bx};
    if (i < fm_obs.size()) r = fm_obs[i];
    return r;
  endfunction

  function automatic wr_t g_at(input int i);
    wr_t r = '{64'hDEAD, 16'hFFFF, 8'h00, 1'bx};
    if (i < g_obs.size()) r = g_obs[i];
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!bus.ctrl_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_ready", 64'(bus.ctrl_ready), 64'd1);
  endtask

  task automatic start_layer(input logic [FAW-1:0] fb,
                             input logic [GAW-1:0] gb);
    wait_idle();
    bus.fm_base_addr_i    = fb;
    bus.guard_base_addr_i = gb;
    bus.ctrl_valid        = 1'b1;
    @(negedge clk);
    bus.ctrl_valid = 1'b0;
    chk("run_ready", 64'({bus.fm_buf_ready, bus.guard_buf_ready}), 64'd3);
  endtask

  // Streams bq/gq with random gaps, then pulses upstream_finish_i and
  // compares every write against words built directly from the queues.
  task automatic run_layer(input logic [FAW-1:0] fb,
                           input logic [GAW-1:0] gb,
                           input bit overlap, input int gap);
    int f0 = fm_obs.size();
    int g0 = g_obs.size();
    int c0 = fin_cnt;
    int nb = bq.size();
    int ng = gq.size();
    int keep = overlap ? 1 : 0;
    int bi = 0;
    int gi = 0;
    int n;
    int nfull;
    int rem;
    int nexp;
    logic [63:0] d;
    logic [63:0] last_d;
    wr_t o;

    start_layer(fb, gb);
    while (bi < nb - keep || gi < ng - keep) begin
      bus.data_i_valid  = 1'b0;
      bus.guard_i_valid = 1'b0;
      if (bi < nb - keep && $urandom_range(99) >= gap) begin
        bus.data_i_valid = 1'b1;
        bus.data_i = bq[bi];
        bi++;
      end
      if (gi < ng - keep && $urandom_range(99) >= gap) begin
        bus.guard_i_valid = 1'b1;
        bus.guard_i = gq[gi];
        gi++;
      end
      @(negedge clk);
    end
    bus.data_i_valid  = (bi < nb);
    bus.guard_i_valid = (gi < ng);
    if (bi < nb) begin bus.data_i = bq[bi]; bi++; end
    if (gi < ng) begin bus.guard_i = gq[gi]; gi++; end
    bus.upstream_finish_i = 1'b1;
    @(negedge clk);
    bus.upstream_finish_i = 1'b0;
    bus.data_i_valid      = 1'b0;
    bus.guard_i_valid     = 1'b0;
    chk("flush_ready", 64'({bus.fm_buf_ready, bus.guard_buf_ready}), 64'd0);

    n = 0;
    while (!bus.ctrl_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_ready", 64'(bus.ctrl_ready), 64'd1);
    chk("finish_pulses", 64'(fin_cnt - c0), 64'd1);

    nfull = nb / W;
    rem   = nb % W;
    nexp  = nfull + ((rem != 0) ? 1 : 0);
    chk("fm_nwr", 64'(fm_obs.size() - f0), 64'(nexp));
    last_d = 64'd0;
    for (int k = 0; k < nexp; k++) begin
      d = 64'd0;
      for (int i = 0; i < W; i++)
        if (k * W + i < nb) d = d | (64'(bq[k*W+i]) << (8 * i));
      o = fm_at(f0 + k);
      chk("fm_data", o.data, d);
      chk("fm_addr", 64'(o.addr), 64'((int'(fb) + k) % (1 << FAW)));
      chk("fm_mask", 64'(o.mask),
          (k < nfull) ? 64'hFF : 64'((1 << rem) - 1));
      chk("fm_fin", 64'(o.fin), (k < nfull) ? 64'd0 : 64'd1);
      last_d = d;
    end
    if (nexp > 0) chk("fm_hold", 64'(bus.fm_wr_data), last_d);

    nfull = ng / G;
    rem   = ng % G;
    nexp  = nfull + ((rem != 0) ? 1 : 0);
    chk("g_nwr", 64'(g_obs.size() - g0), 64'(nexp));
    for (int k = 0; k < nexp; k++) begin
      d = 64'd0;
      for (int i = 0; i < G; i++)
        if (k * G + i < ng) d = d | (64'(gq[k*G+i]) << (6 * i));
      o = g_at(g0 + k);
      chk("g_data", o.data, d);
      chk("g_addr", 64'(o.addr), 64'((int'(gb) + k) % (1 << GAW)));
      chk("g_fin", 64'(o.fin), (k < nfull) ? 64'd0 : 64'd1);
    end

`ifdef FM_GUARD_STAT_EN
    chk("stat_bytes", 64'(bus.stat_bytes_o), 64'(nb));
    chk("stat_guards", 64'(bus.stat_guards_o), 64'(ng));
`else
    chk("stat_bytes", 64'(bus.stat_bytes_o), 64'd0);
    chk("stat_guards", 64'(bus.stat_guards_o), 64'd0);
`endif
  endtask

  initial begin
    int f0;
    int g0;
    int c0;

    bus.ctrl_valid        = 1'b0;
    bus.fm_base_addr_i    = '0;
    bus.guard_base_addr_i = '0;
    bus.upstream_finish_i = 1'b0;
    bus.data_i            = '0;
    bus.data_i_valid      = 1'b0;
    bus.guard_i           = '0;
    bus.guard_i_valid     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ctrl_ready", 64'(bus.ctrl_ready), 64'd1);
    chk("rst_finish", 64'(bus.ctrl_finish), 64'd0);
    chk("rst_readys", 64'({bus.fm_buf_ready, bus.guard_buf_ready}), 64'd0);
    chk("rst_fm_en", 64'(bus.fm_wr_en), 64'd0);
    chk("rst_fm_data", 64'(bus.fm_wr_data), 64'd0);
    chk("rst_fm_addr", 64'(bus.fm_wr_addr), 64'd0);
    chk("rst_fm_mask", 64'(bus.fm_wr_mask), 64'd0);
    chk("rst_g_en", 64'(bus.guard_wr_en), 64'd0);
    chk("rst_g_data", 64'(bus.guard_wr_data), 64'd0);
    chk("rst_stats", 64'({bus.stat_bytes_o, bus.stat_guards_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two full words at 0x010.
    bq.delete(); gq.delete();
    for (int i = 1; i <= 16; i++) bq.push_back(8'(i));
    f0 = fm_obs.size();
    run_layer(10'h010, 8'h00, 1'b0, 0);
    chk("t1_w0", fm_at(f0).data, 64'h0807060504030201);
    chk("t1_w1", fm_at(f0 + 1).data, 64'h100F0E0D0C0B0A09);

    // Five-byte partial flush.
    bq.delete();
    for (int i = 0; i < 5; i++) bq.push_back(8'hA1 + 8'(i));
    f0 = fm_obs.size();
    run_layer(10'h020, 8'h00, 1'b0, 30);
    chk("t2_data", fm_at(f0).data, 64'h000000A5A4A3A2A1);
    chk("t2_mask", 64'(fm_at(f0).mask), 64'h1F);

    // Guard groups: one full word plus a one-group flush.
    bq.delete(); gq.delete();
    gq.push_back(6'h3F); gq.push_back(6'h01); gq.push_back(6'h20);
    gq.push_back(6'h15); gq.push_back(6'h2A);
    g0 = g_obs.size();
    run_layer(10'h000, 8'h40, 1'b0, 0);
    chk("t3_w0", g_at(g0).data, 64'h56007F);
    chk("t3_w1", g_at(g0 + 1).data, 64'h00002A);
    chk("t3_a1", 64'(g_at(g0 + 1).addr), 64'h41);

    // Completing byte arrives with upstream_finish_i.
    bq.delete(); gq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) gq.push_back(6'($urandom));
    run_layer(10'h100, 8'h10, 1'b1, 20);

    // Address wrap.
    bq.delete(); gq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < 9; i++) gq.push_back(6'($urandom));
    f0 = fm_obs.size();
    run_layer(10'h3FF, 8'hFF, 1'b0, 10);
    chk("t5_a0", 64'(fm_at(f0).addr), 64'h3FF);
    chk("t5_a1", 64'(fm_at(f0 + 1).addr), 64'h000);

    // Reset in the middle of a layer.
    f0 = fm_obs.size();
    g0 = g_obs.size();
    c0 = fin_cnt;
    start_layer(10'h055, 8'h22);
    for (int i = 0; i < 3; i++) begin
      bus.data_i_valid  = 1'b1;
      bus.data_i        = 8'($urandom);
      bus.guard_i_valid = (i < 2);
      bus.guard_i       = 6'($urandom);
      @(negedge clk);
    end
    bus.data_i_valid  = 1'b0;
    bus.guard_i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 64'(bus.ctrl_ready), 64'd1);
    chk("mrst_strobes", 64'({bus.fm_wr_en, bus.guard_wr_en}), 64'd0);
    chk("mrst_finish", 64'(bus.ctrl_finish), 64'd0);
    chk("mrst_stats", 64'({bus.stat_bytes_o, bus.stat_guards_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_no_fm", 64'(fm_obs.size() - f0), 64'd0);
    chk("mrst_no_g", 64'(g_obs.size() - g0), 64'd0);
    chk("mrst_no_fin", 64'(fin_cnt - c0), 64'd0);

    bq.delete(); gq.delete();
    for (int i = 0; i < 11; i++) bq.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) gq.push_back(6'($urandom));
    run_layer(10'h055, 8'h22, 1'b0, 0);

    // Random layers.
    for (int t = 0; t < 8; t++) begin
      bq.delete(); gq.delete();
      for (int i = 0; i < int'($urandom_range(40)); i++)
        bq.push_back(8'($urandom));
      for (int i = 0; i < int'($urandom_range(20)); i++)
        gq.push_back(6'($urandom));
      run_layer(10'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(50)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_guard_pack_writer.md
Name: fm_guard_pack_writer

Overview:
- Sits directly downstream of the ReLU/guard write-back stage.
- Consumes its serial 8-bit feature-map byte stream and its 6-bit guard groups.
- Packs bytes into FM buffer SRAM words and guard groups into guard buffer SRAM words.
- Generates write addresses from per-layer base addresses and flushes partial words at end of layer.

Parameters:
FM_WORD_BYTES, 8, bytes per FM SRAM word (power of 2, >=2)
GUARD_GROUPS, 4, 6-bit guard groups per guard SRAM word (>=2)
FM_ADDR_W, 10, FM buffer address width
GUARD_ADDR_W, 8, guard buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ctrl_valid  in  1  layer start request
ctrl_ready  out  1  block idle, can accept start
ctrl_finish  out  1  one-cycle pulse, layer fully written
fm_base_addr_i  in  FM_ADDR_W  first FM word address, latched at start
guard_base_addr_i  in  GUARD_ADDR_W  first guard word address, latched at start
upstream_finish_i  in  1  end-of-layer pulse from upstream stage
data_i  in  8  FM byte
data_i_valid  in  1  byte valid
fm_buf_ready  out  1  byte accepted when high with data_i_valid
guard_i  in  6  guard group
guard_i_valid  in  1  guard group valid
guard_buf_ready  out  1  guard accepted when high with guard_i_valid
fm_wr_en  out  1  FM SRAM write strobe
fm_wr_addr  out  FM_ADDR_W  FM write address
fm_wr_data  out  8*FM_WORD_BYTES  packed bytes
fm_wr_mask  out  FM_WORD_BYTES  per-byte write enable
guard_wr_en  out  1  guard SRAM write strobe
guard_wr_addr  out  GUARD_ADDR_W  guard write address
guard_wr_data  out  6*GUARD_GROUPS  packed guard groups
stat_bytes_o  out  16  bytes accepted this layer (see optional feature)
stat_guards_o  out  16  guard groups accepted this layer (see optional feature)

Behaviour:
- Reset values: ctrl_ready=1. All other outputs 0. FSM in IDLE. Lane counters, address counters and pack registers cleared.
- FSM states:
  - IDLE: ctrl_ready=1. On ctrl_valid&&ctrl_ready: latch both base addresses, clear lanes and stats, go to RUN, ctrl_ready=0 next cycle.
  - RUN: fm_buf_ready=guard_buf_ready=1. On upstream_finish_i go to FLUSH. Any byte/guard valid in that same cycle is accepted.
  - FLUSH: one cycle, both readys=0. Issue the partial FM and/or guard write if its lane counter is nonzero. Then go to DONE.
  - DONE: ctrl_finish=1 for one cycle. Go to IDLE, where ctrl_ready=1 on the following cycle.
- Outside RUN: readys=0 and valids are ignored. ctrl_valid outside IDLE is ignored.
- FM packing:
  - The accepted byte goes to lane fm_lane, occupying fm_wr_data[8*lane+7:8*lane]; lane 0 is the first byte, in the LSBs.
  - fm_lane increments per accept and wraps to 0 after FM_WORD_BYTES-1.
  - The accept that fills the last lane causes, next cycle: fm_wr_en=1, mask all ones, fm_wr_addr = current address.
  - The address counter increments after each write, wrapping mod 2^FM_ADDR_W.
  - Write latency is 1 cycle from the completing accept.
  - The pack register clears to zero after each write, so unfilled lanes of a flush word read 0.
- Guard packing: identical scheme with 6-bit groups and GUARD_GROUPS lanes on the guard port. No mask; a partial flush word is zero-padded.
- Flush write: fm_wr_mask has bits [fm_lane-1:0] set. Issued the cycle after entering FLUSH, coincident with DONE. If the lane counter is 0, no flush write occurs.
- Simultaneous events:
  - FM and guard writes are independent and may strobe in the same cycle.
  - A completing accept in the upstream_finish_i cycle produces a full write in the FLUSH cycle and no extra flush write.
- Strobes are single-cycle. All write outputs are registered. Data, address and mask hold their last value when the strobe is low.
- Reset mid-operation: immediate return to reset values. No partial write is emitted and no ctrl_finish pulse is generated.

Optional Feature:
FM_GUARD_STAT_EN
- Defined: stat_bytes_o and stat_guards_o are registered counts of bytes and guard groups accepted since the last start. They saturate at 16'hFFFF, clear at start, and hold after DONE.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
1. Defaults, base 0x010, bytes 0x01..0x10 then upstream_finish_i:
   - fm writes addr 0x010 data 0x0807060504030201 and addr 0x011 data 0x100F0E0D0C0B0A09, mask 0xFF.
   - No flush write. One ctrl_finish pulse.
2. 5 bytes 0xA1..0xA5 then finish:
   - Single FLUSH write, data 0x000000A5A4A3A2A1, mask 0x1F.
3. Guard groups 0x3F,0x01,0x20,0x15,0x2A then finish:
   - guard write at base: 0x15 in [23:18], 0x20 in [17:12], 0x01 in [11:6], 0x3F in [5:0].
   - Flush write at base+1, data 0x00002A.
4. 8th byte valid in the same cycle as upstream_finish_i:
   - Byte included, full write mask 0xFF, no extra flush write.
5. fm_base_addr_i=0x3FF, 16 bytes: writes at 0x3FF then 0x000.
6. rst_n low during RUN after 3 bytes:
   - No write. ctrl_ready=1, strobes 0. stats=0 with FM_GUARD_STAT_EN.
   - A new start works normally.
